// File: rtl/pio_roundtrip_timer_if.sv
// Avalon-MM slave bundle for pio_roundtrip_timer: register port plus interrupt line.
interface pio_roundtrip_timer_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/pio_roundtrip_timer.sv
// Times HPS request-toggle to stop-toggle intervals seen on an output PIO word,
// echoes the request toggle as an acknowledge and exposes result/status/tag over Avalon-MM.
module pio_roundtrip_timer #(
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned TAG_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           pio_in,
   output logic                  ack_out,
   pio_roundtrip_timer_if.slave  avs
);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_RUNNING = 1'b1;

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam bit                   TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

   logic [0:0]           state_q, state_d;
   logic [1:0]           prev_q;
   logic                 ack_q;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] result_q, result_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic [15:0]          sample_cnt_q, sample_cnt_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 overflow_q, overflow_d;
   logic                 timeout_q, timeout_d;
   logic                 abort_q, abort_d;
   logic                 irq_en_q, irq_en_d;

   logic                 req_evt, stp_evt, wr_en, cnt_sat;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 unused_bits;

   assign req_evt = pio_in[31] ^ prev_q[1];
   assign stp_evt = pio_in[30] ^ prev_q[0];
   assign wr_en   = avs.chipselect & ~avs.write_n;
   assign cnt_sat = &cnt_q;
   assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_WIDTH'(1);

   assign unused_bits = ^{pio_in, avs.writedata};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      result_d     = result_q;
      tag_d        = tag_q;
      sample_cnt_d = sample_cnt_q;
      done_d       = done_q;
      busy_d       = busy_q;
      overflow_d   = overflow_q;
      timeout_d    = timeout_q;
      abort_d      = abort_q;
      irq_en_d     = irq_en_q;

      // Register writes are applied first so an FSM-side done/count update overrides them.
      if (wr_en && avs.address == 2'd1 && avs.writedata[0]) begin
         done_d = 1'b0;
      end
      if (wr_en && avs.address == 2'd3) begin
         irq_en_d = avs.writedata[31];
         if (avs.writedata[0]) begin
            sample_cnt_d = '0;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (req_evt) begin
               state_d    = ST_RUNNING;
               cnt_d      = '0;
               tag_d      = pio_in[TAG_WIDTH-1:0];
               busy_d     = 1'b1;
               overflow_d = 1'b0;
               timeout_d  = 1'b0;
               abort_d    = 1'b0;
            end
         end
         ST_RUNNING: begin
            if (cnt_sat) begin
               overflow_d = 1'b1;
            end
            if (stp_evt) begin
               state_d      = ST_IDLE;
               cnt_d        = cnt_inc;
               result_d     = cnt_inc;
               done_d       = 1'b1;
               busy_d       = 1'b0;
               sample_cnt_d = sample_cnt_q + 16'd1;
            end else if (req_evt) begin
               abort_d = 1'b1;
               cnt_d   = '0;
               tag_d   = pio_in[TAG_WIDTH-1:0];
            end else if (TIMEOUT_EN && cnt_inc == TIMEOUT_VAL) begin
               state_d   = ST_IDLE;
               cnt_d     = cnt_inc;
               result_d  = TIMEOUT_VAL;
               timeout_d = 1'b1;
               done_d    = 1'b1;
               busy_d    = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         prev_q       <= '0;
         ack_q        <= 1'b0;
         cnt_q        <= '0;
         result_q     <= '0;
         tag_q        <= '0;
         sample_cnt_q <= '0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
         timeout_q    <= 1'b0;
         abort_q      <= 1'b0;
         irq_en_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= pio_in[31:30];
         ack_q        <= pio_in[31];
         cnt_q        <= cnt_d;
         result_q     <= result_d;
         tag_q        <= tag_d;
         sample_cnt_q <= sample_cnt_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         overflow_q   <= overflow_d;
         timeout_q    <= timeout_d;
         abort_q      <= abort_d;
         irq_en_q     <= irq_en_d;
      end
   end

   assign ack_out = ack_q;
   assign avs.irq = done_q & irq_en_q;

   always_comb begin
      avs.readdata = '0;
      if (avs.chipselect) begin
         case (avs.address)
            2'd0:    avs.readdata = 32'(result_q);
            2'd1:    avs.readdata = {27'b0, abort_q, timeout_q, overflow_q, busy_q, done_q};
            2'd2:    avs.readdata = 32'(tag_q);
            default: avs.readdata = {irq_en_q, 15'b0, sample_cnt_q};
         endcase
      end
   end

endmodule

// File: tb/tb_pio_roundtrip_timer.sv
// Directed bench for pio_roundtrip_timer: default, timeout-enabled and narrow-counter instances.
module tb_pio_roundtrip_timer;

   logic        clk;
   logic        reset;
   logic [31:0] pio0, pio1, pio2;
   logic        ack0, ack1, ack2;
   int          errors;
   int          checks;
   logic [31:0] d;

   pio_roundtrip_timer_if bus0 ();
   pio_roundtrip_timer_if bus1 ();
   pio_roundtrip_timer_if bus2 ();

   assign bus1.address    = bus0.address;
   assign bus1.chipselect = bus0.chipselect;
   assign bus1.write_n    = bus0.write_n;
   assign bus1.writedata  = bus0.writedata;
   assign bus2.address    = bus0.address;
   assign bus2.chipselect = bus0.chipselect;
   assign bus2.write_n    = bus0.write_n;
   assign bus2.writedata  = bus0.writedata;

   pio_roundtrip_timer #(.CNT_WIDTH(32), .TAG_WIDTH(16), .TIMEOUT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .pio_in(pio0), .ack_out(ack0), .avs(bus0.slave));
   pio_roundtrip_timer #(.CNT_WIDTH(32), .TAG_WIDTH(16), .TIMEOUT_CYCLES(64)) dut1 (
      .clk(clk), .reset(reset), .pio_in(pio1), .ack_out(ack1), .avs(bus1.slave));
   pio_roundtrip_timer #(.CNT_WIDTH(4), .TAG_WIDTH(16), .TIMEOUT_CYCLES(0)) dut2 (
      .clk(clk), .reset(reset), .pio_in(pio2), .ack_out(ack2), .avs(bus2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input int sel, input logic [1:0] a, output logic [31:0] q);
      bus0.chipselect = 1'b1;
      bus0.address    = a;
      #1;
      case (sel)
         0:       q = bus0.readdata;
         1:       q = bus1.readdata;
         default: q = bus2.readdata;
      endcase
      bus0.chipselect = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] v);
      bus0.chipselect = 1'b1;
      bus0.write_n    = 1'b0;
      bus0.address    = a;
      bus0.writedata  = v;
      tick(1);
      bus0.chipselect = 1'b0;
      bus0.write_n    = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack0); end
      checks++; if (bus0.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", bus0.irq); end
      for (int a = 0; a < 4; a++) begin
         rd(0, 2'(a), d);
         checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=00000000", a, d); end
      end
   endtask

   task automatic test_start;
      tick(5);
      pio0 = 32'h8000_00A5;
      checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL start_ack_pre got=%b exp=0", ack0); end
      tick(1);
      checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL start_ack got=%b exp=1", ack0); end
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h02) begin errors++; $display("FAIL start_status got=%h exp=00000002", d); end
      rd(0, 2'd2, d);
      checks++; if (d !== 32'h00A5) begin errors++; $display("FAIL start_tag got=%h exp=000000a5", d); end
   endtask

   task automatic test_stop;
      tick(99);
      pio0 = 32'hC000_00A5;
      tick(1);
      rd(0, 2'd0, d);
      checks++; if (d !== 32'd100) begin errors++; $display("FAIL stop_result got=%0d exp=100", d); end
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h01) begin errors++; $display("FAIL stop_status got=%h exp=00000001", d); end
      rd(0, 2'd3, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL stop_count got=%h exp=00000001", d); end
      checks++; if (bus0.irq !== 1'b0) begin errors++; $display("FAIL stop_irq got=%b exp=0", bus0.irq); end
      bus0.address = 2'd0;
      #1;
      checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL nocs_read got=%h exp=00000000", bus0.readdata); end
   endtask

   task automatic test_idle_events;
      pio0 = 32'h8000_00A5;
      tick(1);
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h01) begin errors++; $display("FAIL idle_stop_status got=%h exp=00000001", d); end
      pio0 = 32'h4000_0033;
      tick(1);
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h03) begin errors++; $display("FAIL idle_both_status got=%h exp=00000003", d); end
      rd(0, 2'd2, d);
      checks++; if (d !== 32'h33) begin errors++; $display("FAIL idle_both_tag got=%h exp=00000033", d); end
      checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL idle_both_ack got=%b exp=0", ack0); end
      tick(4);
      pio0 = 32'h0000_0033;
      tick(1);
      rd(0, 2'd0, d);
      checks++; if (d !== 32'd5) begin errors++; $display("FAIL short_result got=%0d exp=5", d); end
      rd(0, 2'd3, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL short_count got=%h exp=00000002", d); end
   endtask

   task automatic test_irq;
      wr(2'd3, 32'h8000_0000);
      checks++; if (bus0.irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", bus0.irq); end
      rd(0, 2'd3, d);
      checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL irq_reg3 got=%h exp=80000002", d); end
      wr(2'd1, 32'h1);
      checks++; if (bus0.irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", bus0.irq); end
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h00) begin errors++; $display("FAIL irq_status got=%h exp=00000000", d); end
      wr(2'd3, 32'h8000_0001);
      rd(0, 2'd3, d);
      checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL count_clear got=%h exp=80000000", d); end
   endtask

   task automatic test_abort;
      pio0 = 32'h8000_1111;
      tick(1);
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h02) begin errors++; $display("FAIL abort_first_status got=%h exp=00000002", d); end
      tick(19);
      pio0 = 32'h0000_2222;
      tick(1);
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h12) begin errors++; $display("FAIL abort_status got=%h exp=00000012", d); end
      tick(29);
      pio0 = 32'h4000_2222;
      tick(1);
      rd(0, 2'd0, d);
      checks++; if (d !== 32'd30) begin errors++; $display("FAIL abort_result got=%0d exp=30", d); end
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h11) begin errors++; $display("FAIL abort_done_status got=%h exp=00000011", d); end
      rd(0, 2'd2, d);
      checks++; if (d !== 32'h2222) begin errors++; $display("FAIL abort_tag got=%h exp=00002222", d); end
      checks++; if (bus0.irq !== 1'b1) begin errors++; $display("FAIL abort_irq got=%b exp=1", bus0.irq); end
   endtask

   task automatic test_set_wins;
      wr(2'd1, 32'h1);
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h10) begin errors++; $display("FAIL clr_status got=%h exp=00000010", d); end
      pio0 = 32'hC000_2222;
      tick(1);
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h02) begin errors++; $display("FAIL restart_status got=%h exp=00000002", d); end
      pio0 = 32'h8000_2222;
      wr(2'd1, 32'h1);
      rd(0, 2'd0, d);
      checks++; if (d !== 32'd1) begin errors++; $display("FAIL min_result got=%0d exp=1", d); end
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h01) begin errors++; $display("FAIL set_wins_status got=%h exp=00000001", d); end
   endtask

   task automatic test_reset_mid;
      pio0 = 32'h0000_2222;
      tick(1);
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h03) begin errors++; $display("FAIL mid_running got=%h exp=00000003", d); end
      tick(5);
      reset = 1'b1;
      tick(1);
      checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL mid_ack got=%b exp=0", ack0); end
      checks++; if (bus0.irq !== 1'b0) begin errors++; $display("FAIL mid_irq got=%b exp=0", bus0.irq); end
      for (int a = 0; a < 4; a++) begin
         rd(0, 2'(a), d);
         checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reg%0d got=%h exp=00000000", a, d); end
      end
      reset = 1'b0;
      tick(1);
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h00) begin errors++; $display("FAIL post_reset_idle got=%h exp=00000000", d); end
      pio0 = 32'h8000_0007;
      reset = 1'b1;
      tick(1);
      checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL held_ack got=%b exp=0", ack0); end
      reset = 1'b0;
      tick(1);
      rd(0, 2'd1, d);
      checks++; if (d !== 32'h02) begin errors++; $display("FAIL post_reset_req got=%h exp=00000002", d); end
      rd(0, 2'd2, d);
      checks++; if (d !== 32'h7) begin errors++; $display("FAIL post_reset_tag got=%h exp=00000007", d); end
      checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL post_reset_ack got=%b exp=1", ack0); end
   endtask

   task automatic test_timeout_overflow;
      pio1 = 32'h8000_0055;
      pio2 = 32'h8000_0066;
      tick(1);
      tick(19);
      pio2 = 32'hC000_0066;
      tick(1);
      rd(2, 2'd0, d);
      checks++; if (d !== 32'd15) begin errors++; $display("FAIL sat_result got=%0d exp=15", d); end
      rd(2, 2'd1, d);
      checks++; if (d !== 32'h05) begin errors++; $display("FAIL sat_status got=%h exp=00000005", d); end
      tick(43);
      rd(1, 2'd1, d);
      checks++; if (d !== 32'h02) begin errors++; $display("FAIL to_before got=%h exp=00000002", d); end
      tick(1);
      rd(1, 2'd1, d);
      checks++; if (d !== 32'h09) begin errors++; $display("FAIL to_status got=%h exp=00000009", d); end
      rd(1, 2'd0, d);
      checks++; if (d !== 32'd64) begin errors++; $display("FAIL to_result got=%0d exp=64", d); end
   endtask

   initial begin
      errors          = 0;
      checks          = 0;
      reset           = 1'b1;
      pio0            = '0;
      pio1            = '0;
      pio2            = '0;
      bus0.address    = '0;
      bus0.chipselect = 1'b0;
      bus0.write_n    = 1'b1;
      bus0.writedata  = '0;
      test_reset();
      test_start();
      test_stop();
      test_idle_events();
      test_irq();
      test_abort();
      test_set_wins();
      test_reset_mid();
      test_timeout_overflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
